// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, select-field
// codes, FSM state encoding, trap causes and the latched decode record.
package ctrl_pkg;

    // RV32I opcodes handled by this control unit
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU operation codes (zero-extended to CALU_W at the top level)
    localparam logic [2:0] CALU_ADD  = 3'b000;
    localparam logic [2:0] CALU_AND  = 3'b001;
    localparam logic [2:0] CALU_XOR  = 3'b010;
    localparam logic [2:0] CALU_SLL  = 3'b011;
    localparam logic [2:0] CALU_SRL  = 3'b100;
    localparam logic [2:0] CALU_SUB  = 3'b101;
    localparam logic [2:0] CALU_JALR = 3'b110;

    // Immediate extension selects
    localparam logic [2:0] CEU_I = 3'b000;
    localparam logic [2:0] CEU_L = 3'b001;
    localparam logic [2:0] CEU_S = 3'b010;
    localparam logic [2:0] CEU_U = 3'b011;
    localparam logic [2:0] CEU_B = 3'b100;
    localparam logic [2:0] CEU_J = 3'b101;

    // Next-PC selects
    localparam logic [1:0] PCS_BRANCH = 2'b00;
    localparam logic [1:0] PCS_JUMP   = 2'b01;
    localparam logic [1:0] PCS_SEQ    = 2'b10;

    // Writeback data selects
    localparam logic [1:0] DWS_EXT = 2'b00;
    localparam logic [1:0] DWS_ALU = 2'b01;
    localparam logic [1:0] DWS_PC4 = 2'b10;

    // FSM state encoding; FETCH must be 0 so the debug port reads 0 in reset
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_ILL_OP    = 2'b01,
        CAUSE_ILL_FUNCT = 2'b10,
        CAUSE_TIMEOUT   = 2'b11
    } trap_cause_t;

    // Instruction class, used by the FSM to pick the EXEC/MEM path
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_LUI    = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6
    } class_t;

    // Datapath select fields, latched at the end of DECODE
    typedef struct packed {
        logic [2:0] calu;
        logic [2:0] ceu;
        logic [1:0] pcs;
        logic [1:0] dws;
        logic       alus1;
        logic       alus2;
        logic       os;
        logic       bs;
    } sel_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the control unit and the instruction/data
// memories. The control unit is the master: it raises requests and the store
// enable, the memories answer with acks.
interface multicycle_control_unit_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;
    logic cdm;

    modport master (
        output imem_req,
        output dmem_req,
        output cdm,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  cdm,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/control_decoder.sv
// Purely combinational instruction decoder: maps {opcode, funct3, funct7} to the
// datapath select fields and an instruction class, and flags illegal encodings.
// Illegal encodings produce all-zero selects so nothing stray is latched.
module control_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op_code,
    input  logic [2:0] funct_3,
    input  logic [6:0] funct_7,
    output sel_t       sel,
    output class_t     cls,
    output logic       illegal_op,
    output logic       illegal_funct
);

    // Decode table; every field starts at 0 so unlisted fields stay 0
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        sel           = '0;
        cls           = CLS_NONE;
        illegal_op    = 1'b0;
        illegal_funct = 1'b0;

        case (op_code)
            OPC_OP_IMM: begin
                cls       = CLS_ALU;
                sel.ceu   = CEU_I;
                sel.pcs   = PCS_SEQ;
                sel.dws   = DWS_ALU;
                sel.alus1 = 1'b1;
                sel.alus2 = 1'b1;
                case (funct_3)
                    3'b000:  sel.calu = CALU_ADD;
                    3'b111:  sel.calu = CALU_AND;
                    3'b100:  sel.calu = CALU_XOR;
                    3'b001:  sel.calu = CALU_SLL;
                    3'b101:  sel.calu = CALU_SRL;
                    default: illegal_funct = 1'b1;
                endcase
            end

            OPC_LOAD: begin
                if (funct_3 == 3'b010) begin
                    cls       = CLS_LOAD;
                    sel.ceu   = CEU_L;
                    sel.calu  = CALU_ADD;
                    sel.pcs   = PCS_SEQ;
                    sel.dws   = DWS_ALU;
                    sel.alus1 = 1'b1;
                    sel.alus2 = 1'b1;
                    sel.os    = 1'b1;
                end else begin
                    illegal_funct = 1'b1;
                end
            end

            OPC_STORE: begin
                if (funct_3 == 3'b010) begin
                    cls       = CLS_STORE;
                    sel.ceu   = CEU_S;
                    sel.calu  = CALU_ADD;
                    sel.pcs   = PCS_SEQ;
                    sel.alus1 = 1'b1;
                    sel.alus2 = 1'b1;
                end else begin
                    illegal_funct = 1'b1;
                end
            end

            OPC_OP: begin
                cls       = CLS_ALU;
                sel.pcs   = PCS_SEQ;
                sel.dws   = DWS_ALU;
                sel.alus1 = 1'b1;
                sel.alus2 = 1'b0;
                case ({funct_7, funct_3})
                    {7'b0000000, 3'b000}: sel.calu = CALU_ADD;
                    {7'b0000000, 3'b001}: sel.calu = CALU_SLL;
                    {7'b0100000, 3'b000}: sel.calu = CALU_SUB;
                    default:              illegal_funct = 1'b1;
                endcase
            end

            OPC_LUI: begin
                cls     = CLS_LUI;
                sel.ceu = CEU_U;
                sel.pcs = PCS_SEQ;
                sel.dws = DWS_EXT;
            end

            OPC_BRANCH: begin
                if (funct_3 == 3'b001 || funct_3 == 3'b101) begin
                    cls       = CLS_BRANCH;
                    sel.ceu   = CEU_B;
                    sel.calu  = CALU_SUB;
                    sel.pcs   = PCS_BRANCH;
                    sel.alus1 = 1'b1;
                    sel.alus2 = 1'b0;
                    sel.bs    = (funct_3 == 3'b001);
                end else begin
                    illegal_funct = 1'b1;
                end
            end

            OPC_JAL: begin
                cls       = CLS_JUMP;
                sel.ceu   = CEU_J;
                sel.calu  = CALU_ADD;
                sel.pcs   = PCS_JUMP;
                sel.dws   = DWS_PC4;
                sel.alus1 = 1'b0;
                sel.alus2 = 1'b1;
            end

            OPC_JALR: begin
                cls       = CLS_JUMP;
                sel.ceu   = CEU_I;
                sel.calu  = CALU_JALR;
                sel.pcs   = PCS_JUMP;
                sel.dws   = DWS_PC4;
                sel.alus1 = 1'b1;
                sel.alus2 = 1'b1;
            end

            default: illegal_op = 1'b1;
        endcase

        // Never let a half-decoded illegal instruction reach the decode registers
        if (illegal_op || illegal_funct) begin
            sel = '0;
            cls = CLS_NONE;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with variable-latency memories and
// traps on illegal encodings or a memory that never answers.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int CALU_W  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                op_code,
    input  logic [2:0]                funct_3,
    input  logic [6:0]                funct_7,
    multicycle_control_unit_if.master bus,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic                      crf,
    output logic [CALU_W-1:0]         calu,
    output logic [2:0]                ceu,
    output logic [1:0]                pcs,
    output logic [1:0]                dws,
    output logic                      alus1,
    output logic                      alus2,
    output logic                      os,
    output logic                      bs,
    output logic                      trap,
    output logic [1:0]                trap_cause,
    output logic [2:0]                state
);

    // Wide enough to hold the value TIMEOUT itself
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state_q;
    sel_t              sel_q;
    class_t            cls_q;
    trap_cause_t       cause_q;
    logic [CNT_W-1:0]  wait_cnt;

    sel_t              dec_sel;
    class_t            dec_cls;
    logic              dec_ill_op;
    logic              dec_ill_funct;

    logic              timed_out;
    logic              is_mem_cls;

    logic              imem_req_c;
    logic              dmem_req_c;
    logic              cdm_c;

    control_decoder u_decoder (
        .op_code       (op_code),
        .funct_3       (funct_3),
        .funct_7       (funct_7),
        .sel           (dec_sel),
        .cls           (dec_cls),
        .illegal_op    (dec_ill_op),
        .illegal_funct (dec_ill_funct)
    );

    assign timed_out  = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));
    assign is_mem_cls = (cls_q == CLS_LOAD) || (cls_q == CLS_STORE);

    // FSM, decode registers, trap cause and wait counter
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q  <= ST_FETCH;
            sel_q    <= '0;
            cls_q    <= CLS_NONE;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // An ack on the boundary cycle wins over the timeout
                    if (bus.imem_ack) begin
                        state_q  <= ST_DECODE;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        state_q  <= ST_TRAP;
                        cause_q  <= CAUSE_TIMEOUT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_DECODE: begin
                    sel_q <= dec_sel;
                    cls_q <= dec_cls;
                    if (dec_ill_op) begin
                        state_q <= ST_TRAP;
                        cause_q <= CAUSE_ILL_OP;
                    end else if (dec_ill_funct) begin
                        state_q <= ST_TRAP;
                        cause_q <= CAUSE_ILL_FUNCT;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    state_q <= is_mem_cls ? ST_MEM : ST_FETCH;
                end

                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        state_q  <= (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        state_q  <= ST_TRAP;
                        cause_q  <= CAUSE_TIMEOUT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_WB: begin
                    state_q <= ST_FETCH;
                end

                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end

                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes: asserted only in their owning state, all 0 elsewhere
    always_comb begin
        imem_req_c = 1'b0;
        ir_we      = 1'b0;
        dmem_req_c = 1'b0;
        cdm_c      = 1'b0;
        pc_we      = 1'b0;
        crf        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // NOTE: the state register parks in FETCH while reset is held, so the
                // fetch request is qualified with rst to keep every output 0 in reset.
                imem_req_c = rst;
                ir_we      = rst & bus.imem_ack;
            end
            ST_EXEC: begin
                if (!is_mem_cls) begin
                    pc_we = 1'b1;
                    crf   = (cls_q != CLS_BRANCH);
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                cdm_c      = (cls_q == CLS_STORE);
                pc_we      = (cls_q == CLS_STORE) && bus.dmem_ack;
            end
            ST_WB: begin
                crf   = 1'b1;
                pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.imem_req = imem_req_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.cdm      = cdm_c;

    // Select fields always reflect the latched decode
    assign calu       = CALU_W'(sel_q.calu);
    assign ceu        = sel_q.ceu;
    assign pcs        = sel_q.pcs;
    assign dws        = sel_q.dws;
    assign alus1      = sel_q.alus1;
    assign alus2      = sel_q.alus2;
    assign os         = sel_q.os;
    assign bs         = sel_q.bs;

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle RISC-V control unit. It decodes the same RV32I subset (OP-IMM, LOAD, STORE, OP, LUI, BRANCH, JAL, JALR) and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. Instruction and data memories take variable latency and use a req/ack handshake. The block also adds illegal-instruction and bus-timeout traps. It sits between the instruction register and the datapath (register file, extension unit, ALU, data memory, PC mux).

## Interface
Parameters:
- CALU_W, 3: width of the ALU control output. Codes are zero-extended. Must be ≥3.
- TIMEOUT, 16: maximum wait cycles for IMEM_ACK/DMEM_ACK before a bus-timeout trap. 0 disables timeouts.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- OP_CODE  in  7  opcode from the instruction register.
- FUNCT_3  in  3  funct3 from the instruction register.
- FUNCT_7  in  7  funct7 from the instruction register.
- IMEM_ACK  in  1  instruction memory ack; instruction valid this cycle.
- DMEM_ACK  in  1  data memory ack; access complete this cycle.
- IMEM_REQ  out  1  instruction fetch request.
- IR_WE  out  1  instruction register load strobe.
- DMEM_REQ  out  1  data memory request.
- PC_WE  out  1  PC update strobe.
- CRF  out  1  register file write enable.
- CDM  out  1  data memory write enable (store).
- CALU  out  CALU_W  ALU operation.
- CEU  out  3  immediate extension select.
- PCS  out  2  next-PC select.
- DWS  out  2  writeback data select.
- ALUS1  out  1  ALU operand-1 select.
- ALUS2  out  1  ALU operand-2 select.
- OS  out  1  load data select.
- BS  out  1  branch sense (1 = BNE, 0 = BGE).
- TRAP  out  1  sticky trap flag.
- TRAP_CAUSE  out  2  01 illegal opcode, 10 illegal funct, 11 bus timeout.
- STATE  out  3  current state, for debug.

## Operation
**Decode classes.** Registered at the end of DECODE and held until the next DECODE. Fields not listed are 0.
- OP-IMM (0010011): CEU 000; PCS 10; DWS 01; ALUS1 1; ALUS2 1. CALU by funct3: 000→000, 111→001, 100→010, 001→011, 101→100. Any other funct3 → illegal funct.
- LOAD (0000011), funct3 must be 010: CEU 001; CALU 000; PCS 10; DWS 01; ALUS1 1; ALUS2 1; OS 1.
- STORE (0100011), funct3 must be 010: CEU 010; CALU 000; PCS 10; ALUS1 1; ALUS2 1.
- OP (0110011): ALUS1 1; ALUS2 0; PCS 10; DWS 01.
  - {funct7 0000000, funct3 000} → CALU 000.
  - {0000000, 001} → CALU 011.
  - {0100000, 000} → CALU 101.
  - Anything else → illegal funct.
- LUI (0110111): CEU 011; PCS 10; DWS 00.
- BRANCH (1100011), funct3 must be 001 or 101: CEU 100; CALU 101; PCS 00; ALUS1 1; ALUS2 0; BS = (funct3 == 001).
- JAL (1101111): CEU 101; CALU 000; PCS 01; DWS 10; ALUS1 0; ALUS2 1.
- JALR (1100111): CEU 000; CALU 110; PCS 01; DWS 10; ALUS1 1; ALUS2 1.
- Any other opcode → illegal opcode.

**States.**
- FETCH: IMEM_REQ=1. On IMEM_ACK: IR_WE=1 for that cycle, go to DECODE.
- DECODE: latch decode. Illegal → TRAP. Otherwise → EXEC.
- EXEC:
  - LOAD/STORE → MEM.
  - All other classes: PC_WE=1; CRF=1 unless BRANCH; → FETCH.
- MEM: DMEM_REQ=1; CDM=1 for STORE. On DMEM_ACK: LOAD → WB; STORE asserts PC_WE=1 and goes → FETCH.
- WB: CRF=1; OS=1; PC_WE=1; → FETCH.
- TRAP: all strobes 0; TRAP=1. Held until reset.

**Output gating.** Strobes (IMEM_REQ, IR_WE, DMEM_REQ, PC_WE, CRF, CDM) are asserted only in the states listed above. Select outputs drive the latched decode in every state.

**Wait counter.** Clears on every state change. Increments each FETCH/MEM cycle without ack. When it reaches TIMEOUT without ack → TRAP with cause 11.

## Timing
- While RST is low, every output is 0. The state is FETCH, the decode registers are 0, and the counter is 0.
- The first cycle after reset release is FETCH with IMEM_REQ=1.
- An ack is accepted in the same cycle as its request (zero-wait memory). An ack outside FETCH/MEM is ignored.
- Latency with zero-wait memory: ALU/LUI/JAL/JALR/branch 3 cycles; STORE 4 cycles; LOAD 5 cycles. Each wait cycle adds one.
- Reset asserted mid-instruction aborts it immediately. No partial strobes appear after reset.
- An ack in the same cycle the counter reaches TIMEOUT wins: normal transition, no trap.

## Structure
- Package ctrl_pkg holds: opcode constants, CALU codes, CEU/PCS/DWS encodings, the state encoding, and trap-cause codes.
- One combinational sub-module, control_decoder, maps {OP_CODE, FUNCT_3, FUNCT_7} to the select fields plus illegal-opcode and illegal-funct flags.
- The top level holds the FSM, the decode registers, and the wait counter.

## Test plan
- ADDI with zero-wait IMEM: FETCH→DECODE→EXEC. CRF and PC_WE high in cycle 3, CALU=000, DWS=01. FETCH again in cycle 4.
- LW with DMEM_ACK 2 cycles after request: DMEM_REQ high 3 cycles, CDM=0, then WB with CRF=1 and OS=1. Total 7 cycles.
- SW then BNE (funct3 001): SW has CDM=1 during MEM and CRF=0 throughout. BNE has BS=1, PCS=00, CRF=0, PC_WE=1 in EXEC.
- Opcode 1111111 → TRAP, cause 01. SUB-like funct7 0100000 with funct3 001 → TRAP, cause 10. TRAP held for 20 cycles and cleared only by RST low.
- TIMEOUT=4 with IMEM_ACK never asserted → TRAP, cause 11, after 4 wait cycles. Repeat with the ack arriving on the boundary cycle → DECODE, no trap.
- RST pulsed low during MEM of a LW → all outputs 0 asynchronously. After release, FETCH with no CRF pulse.
